// File: rtl/kbc_pkg.sv
// Shared constants and types for the 8042-style keyboard controller.
// Port addresses, controller command codes, status bit positions and the sequencer state.
package kbc_pkg;

   localparam logic [15:0] KBC_DATA_PORT = 16'h0060;
   localparam logic [15:0] KBC_STAT_PORT = 16'h0064;

   localparam logic [7:0] KBC_CMD_READ_CB   = 8'h20;
   localparam logic [7:0] KBC_CMD_WRITE_CB  = 8'h60;
   localparam logic [7:0] KBC_CMD_SELF_TEST = 8'hAA;
   localparam logic [7:0] KBC_CMD_KBD_DIS   = 8'hAD;
   localparam logic [7:0] KBC_CMD_KBD_EN    = 8'hAE;
   localparam logic [7:0] KBC_SELF_TEST_OK  = 8'h55;

   localparam int unsigned KBC_ST_OBF = 0;
   localparam int unsigned KBC_ST_IBF = 1;
   localparam int unsigned KBC_ST_SYS = 2;
   localparam int unsigned KBC_ST_CMD = 3;
   localparam int unsigned KBC_ST_KEN = 4;
   localparam int unsigned KBC_ST_OVF = 5;

   typedef enum logic {
      IDLE,
      WAIT_DATA
   } kbc_state_e;

endpackage

// File: rtl/kbc_fifo.sv
// Synchronous scan-code FIFO; pointers carry one extra wrap bit to tell full from empty.
// Pushes while full and pops while empty are ignored.
module kbc_fifo #(
   parameter int unsigned DEPTH  = 8,
   parameter int unsigned ADDR_W = 3
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_push,
   input  logic       i_pop,
   input  logic [7:0] i_din,
   output logic       o_full,
   output logic       o_empty,
   output logic [7:0] o_dout
);

   logic [7:0]      r_mem [DEPTH];
   logic [ADDR_W:0] r_wr_ptr;
   logic [ADDR_W:0] r_rd_ptr;
   logic            w_do_push;
   logic            w_do_pop;

   assign o_empty   = (r_wr_ptr == r_rd_ptr);
   assign o_full    = (r_wr_ptr[ADDR_W] != r_rd_ptr[ADDR_W]) &&
                      (r_wr_ptr[ADDR_W-1:0] == r_rd_ptr[ADDR_W-1:0]);
   assign w_do_push = i_push & ~o_full;
   assign w_do_pop  = i_pop & ~o_empty;
   assign o_dout    = r_mem[r_rd_ptr[ADDR_W-1:0]];

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (w_do_push) r_mem[r_wr_ptr[ADDR_W-1:0]] <= i_din;
   end

endmodule

// File: rtl/kbc_8042_ctrl.sv
// Minimal 8042 keyboard controller on ports 60h/64h: scan-code FIFO, output-buffer
// arbitration between controller responses and keyboard data, command decode and IRQ1.
module kbc_8042_ctrl
   import kbc_pkg::*;
#(
   parameter int unsigned DEPTH  = 8,
   parameter int unsigned ADDR_W = 3
) (
   input  logic        clock50,
   input  logic        reset_n,
   input  logic [15:0] port_addr,
   output logic [15:0] port_in,
   input  logic [15:0] port_out,
   input  logic        port_bit,
   input  logic        port_clk,
   input  logic        port_read,
   input  logic [7:0]  xt_code,
   input  logic        xt_valid,
   output logic        irq1
);

   kbc_state_e r_state;
   logic [7:0] r_ob_data;
   logic       r_obf;
   logic [7:0] r_cmd_byte;
   logic       r_kbd_en;
   logic       r_sys_flag;
   logic       r_cmd_flag;
   logic       r_ovf;
   logic       r_resp_pend;
   logic [7:0] r_resp;
   logic       r_read;
   logic       r_irq1;

   logic       w_is_data;
   logic       w_is_stat;
   logic       w_rd_edge;
   logic       w_wr_data;
   logic       w_wr_cmd;
   logic       w_push_req;
   logic       w_load_resp;
   logic       w_pop;
   logic       w_full;
   logic       w_empty;
   logic [7:0] w_fifo_dout;
   logic [7:0] w_status;
   logic       w_unused;

   // Upper byte is always zero, so the width qualifier and high write byte carry no meaning.
   assign w_unused = ^{port_bit, port_out[15:8]};

   assign w_is_data   = (port_addr == KBC_DATA_PORT);
   assign w_is_stat   = (port_addr == KBC_STAT_PORT);
   assign w_rd_edge   = r_read & ~port_read;
   assign w_wr_data   = port_clk & w_is_data;
   assign w_wr_cmd    = port_clk & w_is_stat;
   assign w_push_req  = xt_valid & r_kbd_en;
   assign w_load_resp = ~r_obf & r_resp_pend;
   assign w_pop       = ~r_obf & ~r_resp_pend & ~w_empty & r_kbd_en;
   assign irq1        = r_irq1;

   kbc_fifo #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_fifo (
      .i_clk   (clock50),
      .i_rst_n (reset_n),
      .i_push  (w_push_req),
      .i_pop   (w_pop),
      .i_din   (xt_code),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_dout  (w_fifo_dout)
   );

   always_comb begin
      w_status             = 8'h00;
      w_status[KBC_ST_OBF] = r_obf;
      w_status[KBC_ST_SYS] = r_sys_flag;
      w_status[KBC_ST_CMD] = r_cmd_flag;
      w_status[KBC_ST_KEN] = r_kbd_en;
      w_status[KBC_ST_OVF] = r_ovf;
   end

   always_comb begin
      port_in = 16'h0000;
      if (w_is_data)      port_in = {8'h00, r_ob_data};
      else if (w_is_stat) port_in = {8'h00, w_status};
   end

   always_ff @(posedge clock50) begin
      if (!reset_n) begin
         r_state     <= IDLE;
         r_ob_data   <= 8'h00;
         r_obf       <= 1'b0;
         r_cmd_byte  <= 8'h01;
         r_kbd_en    <= 1'b1;
         r_sys_flag  <= 1'b0;
         r_cmd_flag  <= 1'b0;
         r_ovf       <= 1'b0;
         r_resp_pend <= 1'b0;
         r_resp      <= 8'h00;
         r_read      <= 1'b0;
         r_irq1      <= 1'b0;
      end else begin
         r_read <= port_read;
         r_irq1 <= r_obf & r_cmd_byte[0];

         // A dropped byte wins over a same-cycle status read so the overflow is never lost.
         if (w_push_req && w_full)       r_ovf <= 1'b1;
         else if (w_rd_edge && w_is_stat) r_ovf <= 1'b0;

         if (w_load_resp) begin
            r_ob_data   <= r_resp;
            r_resp_pend <= 1'b0;
            r_obf       <= 1'b1;
         end else if (w_pop) begin
            r_ob_data <= w_fifo_dout;
            r_obf     <= 1'b1;
         end else if (w_rd_edge && w_is_data) begin
            r_obf <= 1'b0;
         end

         // Later assignments to r_resp_pend override the load above: a new response
         // command always leaves a byte pending.
         if (w_wr_cmd) begin
            r_cmd_flag <= 1'b1;
            r_state    <= IDLE;
            case (port_out[7:0])
               KBC_CMD_READ_CB: begin
                  r_resp      <= r_cmd_byte;
                  r_resp_pend <= 1'b1;
               end
               KBC_CMD_WRITE_CB: r_state <= WAIT_DATA;
               KBC_CMD_SELF_TEST: begin
                  r_resp      <= KBC_SELF_TEST_OK;
                  r_resp_pend <= 1'b1;
                  r_sys_flag  <= 1'b1;
               end
               KBC_CMD_KBD_DIS: r_kbd_en <= 1'b0;
               KBC_CMD_KBD_EN:  r_kbd_en <= 1'b1;
               default: ;
            endcase
         end else if (w_wr_data) begin
            r_cmd_flag <= 1'b0;
            if (r_state == WAIT_DATA) begin
               r_cmd_byte <= port_out[7:0];
               r_state    <= IDLE;
            end
         end
      end
   end

endmodule

// File: tb/tb_kbc_8042_ctrl.sv
// Scoreboard bench for kbc_8042_ctrl: directed scenarios with fixed expectations, then
// random traffic checked against a queue-based behavioural model of the controller.
module tb_kbc_8042_ctrl;

   localparam int unsigned DEPTH = 8;

   logic        clock50 = 1'b0;
   logic        reset_n;
   logic [15:0] port_addr;
   logic [15:0] port_in;
   logic [15:0] port_out;
   logic        port_bit;
   logic        port_clk;
   logic        port_read;
   logic [7:0]  xt_code;
   logic        xt_valid;
   logic        irq1;

   kbc_8042_ctrl #(
      .DEPTH  (DEPTH),
      .ADDR_W (3)
   ) dut (
      .clock50   (clock50),
      .reset_n   (reset_n),
      .port_addr (port_addr),
      .port_in   (port_in),
      .port_out  (port_out),
      .port_bit  (port_bit),
      .port_clk  (port_clk),
      .port_read (port_read),
      .xt_code   (xt_code),
      .xt_valid  (xt_valid),
      .irq1      (irq1)
   );

   always #5 clock50 = ~clock50;

   typedef struct packed {
      logic [15:0] addr;
      logic [15:0] data;
      logic        irq;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   // Literal expectation for the next read (directed phase); otherwise the model answers.
   bit       g_lit     = 1'b0;
   bit [7:0] g_lit_d   = 8'h00;
   bit       g_lit_irq = 1'b0;

   // Behavioural model state.
   logic [7:0] m_fifo[$];
   bit [7:0]   m_ob, m_cb, m_resp;
   bit         m_obf, m_irq, m_ken, m_sys, m_cmdf, m_ovf, m_rp, m_wait, m_prev;

   function automatic logic [15:0] model_port(input logic [15:0] a);
      if (a == 16'h0060) return {8'h00, m_ob};
      if (a == 16'h0064) return {10'h000, m_ovf, m_ken, m_cmdf, m_sys, 1'b0, m_obf};
      return 16'h0000;
   endfunction

   task automatic model_step(input bit rst_n, input logic [15:0] a, input logic [7:0] wd,
                             input bit wr, input bit rd, input logic [7:0] code, input bit xv);
      bit fall, load_r, load_f, accept, n_irq;
      int sz;
      if (!rst_n) begin
         m_fifo.delete();
         m_ob = 8'h00; m_obf = 0; m_irq = 0; m_cb = 8'h01; m_ken = 1; m_sys = 0;
         m_cmdf = 0; m_ovf = 0; m_rp = 0; m_resp = 8'h00; m_wait = 0; m_prev = 0;
      end else begin
         fall   = m_prev && !rd;
         sz     = m_fifo.size();
         load_r = !m_obf && m_rp;
         load_f = !m_obf && !m_rp && m_ken && (sz > 0);
         accept = xv && m_ken;
         n_irq  = m_obf && m_cb[0];
         if (load_r) begin
            m_ob = m_resp;
            m_rp = 0;
         end else if (load_f) begin
            m_ob = m_fifo.pop_front();
         end
         if (accept && sz == DEPTH) m_ovf = 1;
         else if (fall && a == 16'h0064) m_ovf = 0;
         if (accept && sz < DEPTH) m_fifo.push_back(code);
         if (load_r || load_f) m_obf = 1;
         else if (fall && a == 16'h0060) m_obf = 0;
         if (wr && a == 16'h0064) begin
            m_cmdf = 1;
            m_wait = 0;
            case (wd)
               8'h20: begin m_resp = m_cb; m_rp = 1; end
               8'h60: m_wait = 1;
               8'hAA: begin m_resp = 8'h55; m_rp = 1; m_sys = 1; end
               8'hAD: m_ken = 0;
               8'hAE: m_ken = 1;
               default: ;
            endcase
         end else if (wr && a == 16'h0060) begin
            m_cmdf = 0;
            if (m_wait) begin
               m_cb   = wd;
               m_wait = 0;
            end
         end
         m_irq  = n_irq;
         m_prev = rd;
      end
   endtask

   // Drive one clock cycle of inputs, queue the expected read response, advance the model.
   task automatic step(input bit rst_n, input logic [15:0] a, input logic [7:0] wd,
                       input bit wr, input bit rd, input logic [7:0] code, input bit xv);
      exp_t e;
      reset_n   = rst_n;
      port_addr = a;
      port_out  = {8'($urandom), wd};
      port_bit  = 1'($urandom);
      port_clk  = wr;
      port_read = rd;
      xt_code   = code;
      xt_valid  = xv;
      if (rst_n && rd) begin
         e.addr = a;
         e.data = g_lit ? {8'h00, g_lit_d} : model_port(a);
         e.irq  = g_lit ? g_lit_irq : m_irq;
         exp_q.push_back(e);
      end
      model_step(rst_n, a, wd, wr, rd, code, xv);
      @(posedge clock50);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1, 16'h0000, 8'h00, 0, 0, 8'h00, 0);
   endtask

   task automatic xt(input logic [7:0] c);
      step(1, 16'h0000, 8'h00, 0, 0, c, 1);
   endtask

   task automatic wr(input logic [15:0] a, input logic [7:0] d);
      step(1, a, d, 1, 0, 8'h00, 0);
   endtask

   // Read cycle, falling-edge cycle, then two idle cycles so obf/irq settle.
   task automatic rd(input logic [15:0] a, input logic [7:0] d, input bit irq);
      g_lit     = 1'b1;
      g_lit_d   = d;
      g_lit_irq = irq;
      step(1, a, 8'h00, 0, 1, 8'h00, 0);
      g_lit = 1'b0;
      step(1, a, 8'h00, 0, 0, 8'h00, 0);
      idle(2);
   endtask

   task automatic do_reset(input int n);
      for (int i = 0; i < n; i++) step(0, 16'h0000, 8'h00, 0, 0, 8'h00, 0);
   endtask

   // Monitor: every read cycle presents port_in; compare with the oldest expectation.
   always @(negedge clock50) begin
      exp_t e;
      if (reset_n === 1'b1 && port_read === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL scoreboard_underflow addr=%h got=%h want=<queued entry>",
                     port_addr, port_in);
         end else begin
            e = exp_q.pop_front();
            n_checks++;
            if (port_in === e.data) n_pass++;
            else $display("FAIL port_in addr=%h got=%h want=%h t=%0t",
                          e.addr, port_in, e.data, $time);
            n_checks++;
            if (irq1 === e.irq) n_pass++;
            else $display("FAIL irq1 addr=%h got=%b want=%b t=%0t",
                          e.addr, irq1, e.irq, $time);
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog expired");
   end

   logic [7:0] r_cmd;
   bit         r_rd, r_wr, r_xv;
   logic [15:0] r_a;
   int          rd_odds;

   initial begin
      reset_n = 0; port_addr = 0; port_out = 0; port_bit = 0; port_clk = 0;
      port_read = 0; xt_code = 0; xt_valid = 0;
      @(posedge clock50);
      #1;
      do_reset(3);

      // Single code: latency, status, irq lag, read clears.
      xt(8'h1E);
      rd(16'h0064, 8'h10, 0);
      rd(16'h0064, 8'h11, 1);
      rd(16'h0060, 8'h1E, 1);
      rd(16'h0064, 8'h10, 0);
      rd(16'h0123, 8'h00, 0);

      // Ten codes: one in the output buffer, eight queued, the tenth dropped.
      for (int i = 1; i <= 10; i++) xt(8'(i));
      rd(16'h0064, 8'h31, 1);
      rd(16'h0064, 8'h11, 1);
      for (int i = 1; i <= 9; i++) rd(16'h0060, 8'(i), 1);
      rd(16'h0064, 8'h10, 0);

      // Self-test response jumps ahead of queued keyboard data.
      xt(8'h31); xt(8'h32); xt(8'h33);
      idle(2);
      wr(16'h0064, 8'hAA);
      rd(16'h0064, 8'h1D, 1);
      rd(16'h0060, 8'h31, 1);
      rd(16'h0060, 8'h55, 1);
      rd(16'h0060, 8'h32, 1);
      rd(16'h0060, 8'h33, 1);

      // Command byte 00h masks the interrupt; read it back with 20h.
      wr(16'h0064, 8'h60);
      wr(16'h0060, 8'h00);
      xt(8'h41);
      idle(2);
      rd(16'h0064, 8'h15, 0);
      wr(16'h0064, 8'h20);
      rd(16'h0060, 8'h41, 0);
      rd(16'h0060, 8'h00, 0);
      rd(16'h0064, 8'h1C, 0);
      wr(16'h0064, 8'h60);
      wr(16'h0060, 8'h01);

      // Disabled keyboard ignores new codes but keeps queued ones.
      wr(16'h0064, 8'hAD);
      xt(8'h10);
      idle(2);
      rd(16'h0064, 8'h0C, 0);
      wr(16'h0064, 8'hAE);
      idle(2);
      rd(16'h0064, 8'h1C, 0);
      xt(8'h51); xt(8'h52);
      idle(2);
      wr(16'h0064, 8'hAD);
      rd(16'h0060, 8'h51, 1);
      rd(16'h0064, 8'h0C, 0);
      wr(16'h0064, 8'hAE);
      idle(2);
      rd(16'h0060, 8'h52, 1);
      rd(16'h0064, 8'h1C, 0);

      // Reset with a half-full FIFO, a full output buffer and a pending response.
      for (int i = 0; i < 5; i++) xt(8'(8'h61 + i));
      wr(16'h0064, 8'hAA);
      do_reset(2);
      idle(3);
      rd(16'h0064, 8'h10, 0);
      rd(16'h0060, 8'h00, 0);

      // Random traffic against the model, alternating read-heavy and read-starved blocks.
      do_reset(2);
      for (int blk = 0; blk < 4; blk++) begin
         rd_odds = (blk % 2 == 0) ? 3 : 20;
         for (int c = 0; c < 700; c++) begin
            case ($urandom_range(0, 9))
               0, 1, 2, 3, 4: r_a = 16'h0060;
               5, 6, 7, 8:    r_a = 16'h0064;
               default:       r_a = 16'h0160;
            endcase
            r_rd = ($urandom_range(0, rd_odds - 1) == 0);
            r_wr = ($urandom_range(0, 7) == 0);
            r_xv = ($urandom_range(0, 2) == 0);
            case ($urandom_range(0, 6))
               0: r_cmd = 8'h20;
               1: r_cmd = 8'h60;
               2: r_cmd = 8'hAA;
               3: r_cmd = 8'hAD;
               4, 5: r_cmd = 8'hAE;
               default: r_cmd = 8'($urandom);
            endcase
            if (r_a != 16'h0064) r_cmd = 8'($urandom);
            step(($urandom_range(0, 399) != 0), r_a, r_cmd, r_wr, r_rd, 8'($urandom), r_xv);
         end
      end
      idle(3);

      n_checks++;
      if (exp_q.size() == 0) n_pass++;
      else $display("FAIL scoreboard_leftover got=%0d want=0", exp_q.size());

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
